// File: rtl/vp_pattern_gen.sv
// vp_pattern_gen: raster video source (DE/HSYNC/VSYNC/RGB) with eight selectable test patterns.
// Latency: one cycle from the (h_cnt,v_cnt) position to the registered outputs.
// Flow control: en low freezes position, LFSR and box; outputs idle (DE=0, syncs inactive, pixel=0).
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   en                  run enable
//   mode, fg_color      pattern select and foreground {R,G,B}, both sampled at frame start
//   de_out, h_sync_out,
//   v_sync_out          registered timing outputs (sync level set by SYNC_POL)
//   pixel_out           registered {R,G,B}, zero outside the active area
//   frame_start         one-cycle pulse alongside pixel (0,0)
module vp_pattern_gen #(
  parameter int H_ACTIVE   = 64,
  parameter int H_FP       = 4,
  parameter int H_SYNC     = 8,
  parameter int H_BP       = 4,
  parameter int V_ACTIVE   = 48,
  parameter int V_FP       = 2,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 2,
  parameter bit SYNC_POL   = 1'b1,
  parameter int CHECK_LOG2 = 3,
  parameter int BOX_SIZE   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  mode,
  input  logic [23:0] fg_color,
  output logic        de_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [23:0] pixel_out,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [BW-1:0] bar_pix;   // position inside the current colour bar
  logic [2:0]    bar_idx;   // current colour bar, tracks h_cnt without a divider
  logic [2:0]    mode_q;
  logic [23:0]   fg_q;
  logic [23:0]   lfsr;
  logic [HW-1:0] box_x;
  logic [VW-1:0] box_y;
  logic          started;   // a frame has begun since reset; the box only moves after that

  logic          at_origin, de_c, hs_c, vs_c, in_box, chk;
  logic [2:0]    mode_eff;
  logic [23:0]   fg_eff, lfsr_eff, pix_c, bar_col;
  logic [HW-1:0] box_x_adv, box_x_eff;
  logic [VW-1:0] box_y_adv, box_y_eff;
  logic [7:0]    grey_x, grey_y;

  function automatic logic [23:0] lfsr_step(input logic [23:0] s);
    // Fibonacci form, taps 24,23,22,17
    return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
  endfunction

  always_comb begin
    // Pixel (0,0) is decoded on the same edge that latches the frame
    // parameters, so it must already see the new mode, colour, seed and box.
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    mode_eff  = at_origin ? mode : mode_q;
    fg_eff    = at_origin ? fg_color : fg_q;
    lfsr_eff  = at_origin ? 24'h000001 : lfsr;

    box_x_adv = HW'(int'(box_x) + 1);
    box_y_adv = box_y;
    if (int'(box_x) + 1 + BOX_SIZE > H_ACTIVE) begin
      box_x_adv = '0;
      if (int'(box_y) + 1 + BOX_SIZE > V_ACTIVE) box_y_adv = '0;
      else                                       box_y_adv = VW'(int'(box_y) + 1);
    end
    box_x_eff = (at_origin && started) ? box_x_adv : box_x;
    box_y_eff = (at_origin && started) ? box_y_adv : box_y;

    de_c = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    hs_c = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    vs_c = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);

    in_box = (int'(h_cnt) >= int'(box_x_eff)) && (int'(h_cnt) < int'(box_x_eff) + BOX_SIZE) &&
             (int'(v_cnt) >= int'(box_y_eff)) && (int'(v_cnt) < int'(box_y_eff) + BOX_SIZE);
    grey_x = 8'(h_cnt);
    grey_y = 8'(v_cnt);
    chk    = 1'(h_cnt >> CHECK_LOG2) ^ 1'(v_cnt >> CHECK_LOG2);

    case (bar_idx)
      3'd0:    bar_col = 24'hFFFFFF;
      3'd1:    bar_col = 24'hFFFF00;
      3'd2:    bar_col = 24'h00FFFF;
      3'd3:    bar_col = 24'h00FF00;
      3'd4:    bar_col = 24'hFF00FF;
      3'd5:    bar_col = 24'hFF0000;
      3'd6:    bar_col = 24'h0000FF;
      default: bar_col = 24'h000000;
    endcase

    case (mode_eff)
      3'd0:    pix_c = fg_eff;
      3'd1:    pix_c = {grey_x, grey_x, grey_x};
      3'd2:    pix_c = {grey_y, grey_y, grey_y};
      3'd3:    pix_c = chk ? fg_eff : 24'h000000;
      3'd4:    pix_c = bar_col;
      3'd5:    pix_c = in_box ? fg_eff : 24'h000000;
      3'd6:    pix_c = lfsr_eff;
      default: pix_c = 24'h000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_pix     <= '0;
      bar_idx     <= '0;
      mode_q      <= '0;
      fg_q        <= '0;
      lfsr        <= 24'h000001;
      box_x       <= '0;
      box_y       <= '0;
      started     <= 1'b0;
      de_out      <= 1'b0;
      h_sync_out  <= ~SYNC_POL;
      v_sync_out  <= ~SYNC_POL;
      pixel_out   <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      de_out      <= 1'b0;
      h_sync_out  <= ~SYNC_POL;
      v_sync_out  <= ~SYNC_POL;
      pixel_out   <= '0;
      frame_start <= 1'b0;
    end else begin
      de_out      <= de_c;
      h_sync_out  <= hs_c ? SYNC_POL : ~SYNC_POL;
      v_sync_out  <= vs_c ? SYNC_POL : ~SYNC_POL;
      pixel_out   <= de_c ? pix_c : 24'h000000;
      frame_start <= at_origin;

      if (at_origin) begin
        mode_q  <= mode;
        fg_q    <= fg_color;
        box_x   <= box_x_eff;
        box_y   <= box_y_eff;
        started <= 1'b1;
      end
      lfsr <= de_c ? lfsr_step(lfsr_eff) : lfsr_eff;

      if (int'(h_cnt) == H_TOTAL - 1) begin
        h_cnt   <= '0;
        bar_pix <= '0;
        bar_idx <= '0;
        if (int'(v_cnt) == V_TOTAL - 1) v_cnt <= '0;
        else                             v_cnt <= v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
        if (int'(bar_pix) == BAR_W - 1) begin
          bar_pix <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pix <= bar_pix + BW'(1);
        end
      end
    end
  end
endmodule
